// File: rtl/sd_cmd_responder.sv
// Card-side SD CMD line responder: receives 48-bit host commands on SD_CLK rises,
// checks CRC7, decodes CMD0/CMD8/CMD55/ACMD41 and returns R1/R3/R7 on SD_CLK falls.
module sd_cmd_responder #(
  parameter int          NCR        = 2,
  parameter logic [31:0] OCR_VALUE  = 32'h00FF8000,
  parameter int          INIT_COUNT = 2
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        SD_CLK,
  input  logic        CMD_IN,
  output logic        CMD_OUT,
  output logic        CMD_OE,
  output logic        CMD_VALID,
  output logic [5:0]  CMD_INDEX,
  output logic [31:0] CMD_ARG,
  output logic        CRC_ERR,
  output logic        CARD_READY
);

  typedef enum logic [2:0] {HUNT, RECV, CHECK, WAIT_NCR, SEND} state_t;
  typedef enum logic [1:0] {RSP_NONE, RSP_R1, RSP_R3, RSP_R7} resp_t;

  localparam logic [7:0] NCR_LAST = 8'(NCR - 1);
  localparam logic [7:0] INIT_LIM = 8'(INIT_COUNT);

  state_t      state_r, state_next_s;
  logic        sd_meta_r, sd_sync_r, sd_prev_r;
  logic        cmd_meta_r, cmd_sync_r;
  logic        rise_s, fall_s, cmd_bit_s;
  logic [47:0] frame_r;
  logic [5:0]  bit_cnt_r;
  logic [7:0]  ncr_cnt_r;
  logic [5:0]  send_cnt_r;
  logic [47:0] resp_r;
  logic        app_cmd_r, crc_flag_r;
  logic [7:0]  init_cnt_r;

  logic [5:0]  idx_s;
  logic [31:0] arg_s;
  logic        crc_ok_s, app_next_s, illegal_s, ready_next_s;
  logic [7:0]  init_next_s;
  resp_t       resp_kind_s;
  logic [31:0] r1_status_s, content_s;
  logic [5:0]  idx_field_s;
  logic [39:0] resp_body_s;
  logic [6:0]  resp_crc_s;

  function automatic logic [6:0] crc7(input logic [39:0] d);
    logic [6:0] c;
    logic       fb;
    c = 7'd0;
    for (int i = 39; i >= 0; i--) begin
      fb = d[i] ^ c[6];
      c  = {c[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
    end
    return c;
  endfunction

  // SD_CLK and CMD_IN pass through matching synchroniser depths so data stays aligned with the edge.
  assign rise_s    = sd_sync_r & ~sd_prev_r;
  assign fall_s    = ~sd_sync_r & sd_prev_r;
  assign cmd_bit_s = cmd_sync_r;
  assign idx_s     = frame_r[45:40];
  assign arg_s     = frame_r[39:8];
  assign crc_ok_s  = (crc7(frame_r[47:8]) == frame_r[7:1]) && frame_r[0];

  // Command decode and response assembly, evaluated while the frame sits in CHECK.
  always_comb begin
    app_next_s   = 1'b0;
    illegal_s    = 1'b0;
    ready_next_s = CARD_READY;
    init_next_s  = init_cnt_r;
    resp_kind_s  = RSP_NONE;
    case (idx_s)
      6'd0: begin
        ready_next_s = 1'b0;
        init_next_s  = 8'd0;
      end
      6'd8: begin
        if (arg_s[11:8] == 4'h1) resp_kind_s = RSP_R7;
        else                     resp_kind_s = RSP_NONE;
      end
      6'd55: begin
        app_next_s  = 1'b1;
        resp_kind_s = RSP_R1;
      end
      6'd41: begin
        if (app_cmd_r) begin
          init_next_s  = (init_cnt_r == 8'hFF) ? init_cnt_r : init_cnt_r + 8'd1;
          ready_next_s = (init_cnt_r >= INIT_LIM) ? 1'b1 : CARD_READY;
          resp_kind_s  = RSP_R3;
        end else begin
          illegal_s   = 1'b1;
          resp_kind_s = RSP_R1;
        end
      end
      default: begin
        illegal_s   = 1'b1;
        resp_kind_s = RSP_R1;
      end
    endcase

    r1_status_s = {8'h00, crc_flag_r, illegal_s, 9'h000, 3'b000, ready_next_s,
                   1'b1, 2'b00, app_next_s, 5'h00};
    case (resp_kind_s)
      RSP_R3: begin
        content_s   = {ready_next_s, OCR_VALUE[30:0]};
        idx_field_s = 6'h3F;
      end
      RSP_R7: begin
        content_s   = {20'h00000, arg_s[11:0]};
        idx_field_s = idx_s;
      end
      default: begin
        content_s   = r1_status_s;
        idx_field_s = idx_s;
      end
    endcase
    resp_body_s = {2'b00, idx_field_s, content_s};
    resp_crc_s  = (resp_kind_s == RSP_R3) ? 7'h7F : crc7(resp_body_s);
  end

  // FSM state register.
  always_ff @(posedge CLK) begin
    if (!RST_N) state_r <= HUNT;
    else        state_r <= state_next_s;
  end

  // FSM next-state logic; transitions only advance on detected SD_CLK edges.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      HUNT: begin
        if (rise_s && !cmd_bit_s) state_next_s = RECV;
        else                      state_next_s = HUNT;
      end
      RECV: begin
        if (rise_s && bit_cnt_r == 6'd1 && !cmd_bit_s) state_next_s = HUNT;
        else if (rise_s && bit_cnt_r == 6'd47)         state_next_s = CHECK;
        else                                           state_next_s = RECV;
      end
      CHECK: begin
        if (!crc_ok_s)                    state_next_s = HUNT;
        else if (resp_kind_s != RSP_NONE) state_next_s = WAIT_NCR;
        else                              state_next_s = HUNT;
      end
      WAIT_NCR: begin
        if (fall_s && ncr_cnt_r == NCR_LAST) state_next_s = SEND;
        else                                 state_next_s = WAIT_NCR;
      end
      SEND: begin
        if (fall_s && send_cnt_r == 6'd48) state_next_s = HUNT;
        else                               state_next_s = SEND;
      end
      default: state_next_s = HUNT;
    endcase
  end

  // Datapath: synchronisers, frame shifter, card state and response serialiser.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      sd_meta_r  <= 1'b0;
      sd_sync_r  <= 1'b0;
      sd_prev_r  <= 1'b0;
      cmd_meta_r <= 1'b1;
      cmd_sync_r <= 1'b1;
      frame_r    <= 48'd0;
      bit_cnt_r  <= 6'd0;
      ncr_cnt_r  <= 8'd0;
      send_cnt_r <= 6'd0;
      resp_r     <= 48'd0;
      app_cmd_r  <= 1'b0;
      crc_flag_r <= 1'b0;
      init_cnt_r <= 8'd0;
      CMD_OUT    <= 1'b1;
      CMD_OE     <= 1'b0;
      CMD_VALID  <= 1'b0;
      CMD_INDEX  <= 6'd0;
      CMD_ARG    <= 32'd0;
      CRC_ERR    <= 1'b0;
      CARD_READY <= 1'b0;
    end else begin
      sd_meta_r  <= SD_CLK;
      sd_sync_r  <= sd_meta_r;
      sd_prev_r  <= sd_sync_r;
      cmd_meta_r <= CMD_IN;
      cmd_sync_r <= cmd_meta_r;
      CMD_VALID  <= 1'b0;
      CRC_ERR    <= 1'b0;
      case (state_r)
        HUNT: begin
          if (rise_s && !cmd_bit_s) begin
            frame_r   <= 48'd0;
            bit_cnt_r <= 6'd1;
          end
        end
        RECV: begin
          if (rise_s) begin
            frame_r   <= {frame_r[46:0], cmd_bit_s};
            bit_cnt_r <= bit_cnt_r + 6'd1;
          end
        end
        CHECK: begin
          ncr_cnt_r  <= 8'd0;
          send_cnt_r <= 6'd0;
          if (crc_ok_s) begin
            CMD_VALID  <= 1'b1;
            CMD_INDEX  <= idx_s;
            CMD_ARG    <= arg_s;
            app_cmd_r  <= app_next_s;
            init_cnt_r <= init_next_s;
            CARD_READY <= ready_next_s;
            resp_r     <= {resp_body_s, resp_crc_s, 1'b1};
            // crc_flag is consumed by the R1 that reports it.
            if (resp_kind_s == RSP_R1) crc_flag_r <= 1'b0;
          end else begin
            CRC_ERR    <= 1'b1;
            crc_flag_r <= 1'b1;
          end
        end
        WAIT_NCR: begin
          if (fall_s) ncr_cnt_r <= ncr_cnt_r + 8'd1;
        end
        SEND: begin
          if (fall_s) begin
            if (send_cnt_r != 6'd48) begin
              CMD_OE     <= 1'b1;
              CMD_OUT    <= resp_r[47];
              resp_r     <= {resp_r[46:0], 1'b1};
              send_cnt_r <= send_cnt_r + 6'd1;
            end else begin
              CMD_OE  <= 1'b0;
              CMD_OUT <= 1'b1;
            end
          end
        end
        default: begin
          CMD_OE  <= 1'b0;
          CMD_OUT <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sd_cmd_responder.sv
// Host-side bench for sd_cmd_responder: drives command frames, models the pulled-up
// CMD bus, and compares received responses against a queue of expected frames.
module tb_sd_cmd_responder;

  localparam int NCR = 2;

  logic        clk, rst_n, sd_clk, host_cmd;
  logic        cmd_bus;
  logic        cmd_out, cmd_oe, cmd_valid, crc_err, card_ready;
  logic [5:0]  cmd_index;
  logic [31:0] cmd_arg;

  logic [47:0] exp_q[$];
  int          checks_total = 0;
  int          checks_passed = 0;
  int          valid_cnt = 0;
  int          err_cnt = 0;

  sd_cmd_responder #(.NCR(NCR), .OCR_VALUE(32'h00FF8000), .INIT_COUNT(2)) dut (
    .CLK(clk), .RST_N(rst_n), .SD_CLK(sd_clk), .CMD_IN(cmd_bus),
    .CMD_OUT(cmd_out), .CMD_OE(cmd_oe), .CMD_VALID(cmd_valid),
    .CMD_INDEX(cmd_index), .CMD_ARG(cmd_arg), .CRC_ERR(crc_err),
    .CARD_READY(card_ready)
  );

  assign cmd_bus = cmd_oe ? cmd_out : host_cmd;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  initial sd_clk = 1'b0;
  always #80 sd_clk = ~sd_clk;

  always @(posedge clk) begin
    if (cmd_valid) valid_cnt <= valid_cnt + 1;
    if (crc_err)   err_cnt   <= err_cnt + 1;
  end

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks_total++;
    if (obs === exp) checks_passed++;
    else $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [6:0] tb_crc7(input logic [39:0] d);
    logic [6:0] r;
    logic       inv;
    r = 7'd0;
    for (int i = 39; i >= 0; i--) begin
      inv  = d[i] ^ r[6];
      r[6] = r[5]; r[5] = r[4]; r[4] = r[3];
      r[3] = r[2] ^ inv;
      r[2] = r[1]; r[1] = r[0];
      r[0] = inv;
    end
    return r;
  endfunction

  function automatic logic [47:0] mk_cmd(input logic [5:0] idx, input logic [31:0] arg);
    return {2'b01, idx, arg, tb_crc7({2'b01, idx, arg}), 1'b1};
  endfunction

  function automatic logic [47:0] mk_resp(input logic [5:0] idx, input logic [31:0] content);
    return {2'b00, idx, content, tb_crc7({2'b00, idx, content}), 1'b1};
  endfunction

  function automatic logic [31:0] r1_word(input logic crcf, input logic ill,
                                          input logic rdy, input logic app);
    logic [31:0] w;
    w = 32'h0000_0100;
    if (crcf) w = w | 32'h0080_0000;
    if (ill)  w = w | 32'h0040_0000;
    if (rdy)  w = w | 32'h0000_0200;
    if (app)  w = w | 32'h0000_0020;
    return w;
  endfunction

  task automatic send_frame(input logic [47:0] f);
    for (int i = 47; i >= 0; i--) begin
      @(negedge sd_clk);
      host_cmd = f[i];
    end
    @(negedge sd_clk);
    host_cmd = 1'b1;
  endtask

  task automatic get_resp(output logic [47:0] r, output int lat, output bit ok);
    ok  = 1'b0;
    lat = 0;
    r   = 48'd0;
    for (int i = 1; i <= 100 && !ok; i++) begin
      @(posedge sd_clk);
      if (cmd_bus == 1'b0) begin
        ok  = 1'b1;
        lat = i;
      end
    end
    if (ok) begin
      for (int b = 46; b >= 0; b--) begin
        @(posedge sd_clk);
        r[b] = cmd_bus;
      end
    end
  endtask

  task automatic do_cmd(input string tag, input logic [47:0] f, input bit has_resp,
                        input logic [47:0] exp);
    logic [47:0] r;
    int          lat;
    bit          ok;
    bit          oe_seen;
    if (has_resp) exp_q.push_back(exp);
    send_frame(f);
    if (has_resp) begin
      get_resp(r, lat, ok);
      check_eq({tag, "_start"}, ok, 1'b1);
      if (ok) begin
        check_eq({tag, "_ncr"}, lat, NCR + 1);
        check_eq({tag, "_resp"}, r, exp_q.pop_front());
        @(posedge sd_clk);
        check_eq({tag, "_release"}, cmd_oe, 1'b0);
      end else begin
        void'(exp_q.pop_front());
      end
    end else begin
      oe_seen = 1'b0;
      for (int i = 0; i < 100; i++) begin
        @(posedge sd_clk);
        if (cmd_oe) oe_seen = 1'b1;
      end
      check_eq({tag, "_noresp"}, oe_seen, 1'b0);
    end
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int  v0, e0;
    bit  ok;
    rst_n    = 1'b0;
    host_cmd = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check_eq("rst_out",   cmd_out, 1'b1);
    check_eq("rst_oe",    cmd_oe, 1'b0);
    check_eq("rst_valid", cmd_valid, 1'b0);
    check_eq("rst_index", cmd_index, 6'd0);
    check_eq("rst_arg",   cmd_arg, 32'd0);
    check_eq("rst_crcerr", crc_err, 1'b0);
    check_eq("rst_ready", card_ready, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge sd_clk);

    v0 = valid_cnt;
    do_cmd("cmd0", 48'h40_0000_0000_95, 1'b0, 48'd0);
    check_eq("cmd0_valid", valid_cnt - v0, 1);
    check_eq("cmd0_index", cmd_index, 6'd0);

    do_cmd("cmd8", 48'h48_0000_01AA_87, 1'b1, 48'h08_0000_01AA_13);
    check_eq("cmd8_index", cmd_index, 6'd8);
    check_eq("cmd8_arg", cmd_arg, 32'h0000_01AA);

    do_cmd("cmd55", 48'h77_0000_0000_65, 1'b1, 48'h37_0000_0120_83);

    for (int k = 0; k < 3; k++) begin
      do_cmd("pre55", mk_cmd(6'd55, 32'd0), 1'b1, mk_resp(6'd55, r1_word(1'b0, 1'b0, 1'b0, 1'b1)));
      do_cmd("acmd41", mk_cmd(6'd41, 32'h40FF_8000), 1'b1,
             (k < 2) ? 48'h3F_00FF_8000_FF : 48'h3F_80FF_8000_FF);
      check_eq("acmd41_ready", card_ready, (k == 2) ? 1'b1 : 1'b0);
    end

    do_cmd("cmd41_noapp", mk_cmd(6'd41, 32'd0), 1'b1,
           mk_resp(6'd41, r1_word(1'b0, 1'b1, 1'b1, 1'b0)));

    do_cmd("cmd0_idle", 48'h40_0000_0000_95, 1'b0, 48'd0);
    check_eq("cmd0_idle_ready", card_ready, 1'b0);

    e0 = err_cnt;
    v0 = valid_cnt;
    do_cmd("cmd0_endbit", 48'h40_0000_0000_94, 1'b0, 48'd0);
    check_eq("endbit_crcerr", err_cnt - e0, 1);
    check_eq("endbit_valid", valid_cnt - v0, 0);

    do_cmd("cmd55_flag", 48'h77_0000_0000_65, 1'b1, mk_resp(6'd55, 32'h0080_0120));
    do_cmd("cmd55_clr",  48'h77_0000_0000_65, 1'b1, mk_resp(6'd55, 32'h0000_0120));

    e0 = err_cnt;
    do_cmd("cmd0_badcrc", 48'h40_0000_0000_97, 1'b0, 48'd0);
    check_eq("badcrc_crcerr", err_cnt - e0, 1);

    do_cmd("cmd8_badarg", mk_cmd(6'd8, 32'h0000_02AA), 1'b0, 48'd0);
    check_eq("cmd8_badarg_arg", cmd_arg, 32'h0000_02AA);

    // Reset while the card is mid-response.
    send_frame(48'h48_0000_01AA_87);
    ok = 1'b0;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(posedge sd_clk);
      if (cmd_bus == 1'b0) ok = 1'b1;
    end
    check_eq("rstsend_start", ok, 1'b1);
    repeat (20) @(posedge sd_clk);
    check_eq("rstsend_oe_before", cmd_oe, 1'b1);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check_eq("rstsend_oe", cmd_oe, 1'b0);
    check_eq("rstsend_out", cmd_out, 1'b1);
    check_eq("rstsend_index", cmd_index, 6'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge sd_clk);

    do_cmd("cmd8_after_rst", 48'h48_0000_01AA_87, 1'b1, 48'h08_0000_01AA_13);

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
